// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings, bridge FSM state type and system memory-map bases.
package axi4_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RADDR = 3'd1,
        ST_RDATA = 3'd2,
        ST_WREQ  = 3'd3,
        ST_WRESP = 3'd4
    } state_t;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [2:0] AXI_SIZE_1B = 3'b000;
    localparam logic [2:0] AXI_SIZE_2B = 3'b001;
    localparam logic [2:0] AXI_SIZE_4B = 3'b010;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [31:0] MEM_BASE    = 32'h8000_0000;
    localparam logic [31:0] PERIPH_BASE = 32'hA000_0000;

endpackage

// File: rtl/axi4_master_bridge.sv
// Converts single-request client transactions into AXI4 bursts: reads of
// req_len+1 beats, single-beat 32-bit writes, one outstanding at a time.
module axi4_master_bridge
    import axi4_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'h0
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [7:0]  req_len,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,

    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_last,
    output logic        resp_err,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic [3:0]  awqos,
    output logic        awvalid,
    input  logic        awready,

    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic [3:0]  arqos,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output state_t      fsm_state
);

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic [7:0]  len_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [7:0]  cnt_q;
    logic        aw_done_q;
    logic        w_done_q;
    logic        beat_mismatch;
    logic        req_hs;
    logic        r_hs;

    // Only one transaction is ever in flight, so ID fields carry no information.
    logic unused_ids;
    assign unused_ids = ^{rid, bid};

    assign req_hs        = req_valid && req_ready;
    assign r_hs          = rvalid && rready;
    assign beat_mismatch = (rlast && (cnt_q != 8'd0)) || ((cnt_q == 8'd0) && !rlast);

    // Payloads come straight from registers written only in IDLE, which keeps
    // them stable for as long as any valid is pending.
    assign awid    = AXI_ID;
    assign awaddr  = addr_q;
    assign awlen   = 8'd0;
    assign awsize  = AXI_SIZE_4B;
    assign awburst = AXI_BURST_INCR;
    assign awlock  = 1'b0;
    assign awcache = 4'b0011;
    assign awprot  = 3'b000;
    assign awqos   = 4'd0;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wlast   = 1'b1;

    assign arid    = AXI_ID;
    assign araddr  = addr_q;
    assign arlen   = len_q;
    assign arsize  = AXI_SIZE_4B;
    assign arburst = AXI_BURST_INCR;
    assign arlock  = 1'b0;
    assign arcache = 4'b0011;
    assign arprot  = 3'b000;
    assign arqos   = 4'd0;

    assign fsm_state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        arvalid    = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        rready     = 1'b0;
        bready     = 1'b0;
        resp_valid = 1'b0;
        resp_data  = 32'd0;
        resp_last  = 1'b0;
        resp_err   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = req_write ? ST_WREQ : ST_RADDR;
                end
            end
            ST_RADDR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_d = ST_RDATA;
                end
            end
            ST_RDATA: begin
                rready     = resp_ready;
                resp_valid = rvalid;
                resp_data  = rdata;
                resp_last  = rlast;
                resp_err   = (rresp != AXI_RESP_OKAY) || beat_mismatch;
                if (rvalid && resp_ready && rlast) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WREQ: begin
                awvalid = !aw_done_q;
                wvalid  = !w_done_q;
                // A channel already done counts as complete; otherwise its
                // ready this cycle completes it (valid is high in that case).
                if ((aw_done_q || awready) && (w_done_q || wready)) begin
                    state_d = ST_WRESP;
                end
            end
            ST_WRESP: begin
                bready     = resp_ready;
                resp_valid = bvalid;
                resp_err   = (bresp != AXI_RESP_OKAY);
                resp_last  = 1'b1;
                if (bvalid && resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= 32'd0;
            len_q     <= 8'd0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            cnt_q     <= 8'd0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            if (req_hs) begin
                addr_q  <= req_addr;
                len_q   <= req_len;
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
                cnt_q   <= req_len;
            end else if ((state_q == ST_RDATA) && r_hs) begin
                // Saturate so surplus beats beyond the count keep flagging errors.
                cnt_q <= (cnt_q == 8'd0) ? 8'd0 : cnt_q - 8'd1;
            end

            if (state_q == ST_WREQ) begin
                if (awvalid && awready) begin
                    aw_done_q <= 1'b1;
                end
                if (wvalid && wready) begin
                    w_done_q <= 1'b1;
                end
            end else begin
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi4_master_bridge.sv
// Directed bench for axi4_master_bridge: scripted AXI slave, response
// scoreboard and channel payload/handshake monitor.
module tb_axi4_master_bridge;
    import axi4_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [7:0]  req_len;
    logic [3:0]  req_wstrb;
    logic        resp_valid, resp_ready, resp_last, resp_err;
    logic [31:0] resp_data;
    logic [3:0]  awid, awcache, awqos, arid, arcache, arqos, bid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize, awprot, arprot;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awlock, arlock, awvalid, awready, wvalid, wready, wlast;
    logic        bvalid, bready, arvalid, arready, rvalid, rready, rlast;
    logic [3:0]  wstrb;
    state_t      fsm_state;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [33:0] exp_q[$];
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, resp_cnt = 0;
    logic [31:0] exp_addr, exp_wdata;
    logic [7:0]  exp_len;
    logic [3:0]  exp_wstrb;
    logic        rr_toggle = 1'b0;

    axi4_master_bridge dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_last(resp_last), .resp_err(resp_err),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awqos(awqos),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arqos(arqos),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .fsm_state(fsm_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached with %0d compared", n_cmp);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // resp_ready either held high or toggled every cycle.
    initial begin
        resp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            resp_ready = rr_toggle ? ~resp_ready : 1'b1;
        end
    end

    // Monitor: scoreboard pops, handshake counts, payload and stability checks.
    initial begin
        logic        p_ar, p_aw, p_w;
        logic [31:0] p_araddr, p_awaddr, p_wdata;
        logic [33:0] e;
        p_ar = 1'b0; p_aw = 1'b0; p_w = 1'b0;
        p_araddr = '0; p_awaddr = '0; p_wdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_ar = 1'b0; p_aw = 1'b0; p_w = 1'b0;
            end else begin
                if (resp_valid && resp_ready) begin
                    resp_cnt++;
                    if (exp_q.size() == 0) begin
                        check("resp_unexpected", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_err_last_data", {30'd0, resp_err, resp_last, resp_data}, {30'd0, e});
                    end
                end
                if (arvalid && arready) begin
                    ar_cnt++;
                    check("ar_payload", {arlen, araddr, arsize, arburst, arid},
                          {exp_len, exp_addr, 3'b010, 2'b01, 4'h0});
                end
                if (awvalid && awready) begin
                    aw_cnt++;
                    check("aw_payload", {awaddr, awlen, awsize, awburst, awid},
                          {exp_addr, 8'd0, 3'b010, 2'b01, 4'h0});
                end
                if (wvalid && wready) begin
                    w_cnt++;
                    check("w_payload", {wdata, wstrb, wlast}, {exp_wdata, exp_wstrb, 1'b1});
                end
                if (arvalid && p_ar) check("ar_stable", araddr, p_araddr);
                if (awvalid && p_aw) check("aw_stable", awaddr, p_awaddr);
                if (wvalid && p_w)   check("w_stable", wdata, p_wdata);
                p_ar = arvalid && !arready; p_araddr = araddr;
                p_aw = awvalid && !awready; p_awaddr = awaddr;
                p_w  = wvalid && !wready;   p_wdata  = wdata;
            end
        end
    end

    task automatic wait_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic wr, input logic [31:0] addr, input logic [7:0] len,
                            input logic [31:0] wd, input logic [3:0] ws);
        int guard = 0;
        exp_addr  = addr;
        exp_len   = wr ? 8'd0 : len;
        exp_wdata = wd;
        exp_wstrb = ws;
        req_valid = 1'b1; req_write = wr; req_addr = addr;
        req_len   = len;  req_wdata = wd; req_wstrb = ws;
        while (!req_ready && guard < 50) begin
            wait_cycle();
            guard++;
        end
        if (guard >= 50) check("req_timeout", 64'd1, 64'd0);
        wait_cycle();
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    // Read slave: accepts AR, then presents nsend beats; beat last_idx carries
    // rlast, beat bad_idx carries rresp=3. Expected error follows the beat-count rules.
    task automatic slave_read(input logic [7:0] len, input int nsend, input int last_idx,
                              input int bad_idx, input logic [31:0] base);
        int guard = 0;
        logic hs, lst, e;
        logic [7:0] cnt;
        logic [1:0] rr;
        while (!arvalid && guard < 50) begin
            wait_cycle();
            guard++;
        end
        if (guard >= 50) check("ar_timeout", 64'd1, 64'd0);
        arready = 1'b1;
        wait_cycle();
        arready = 1'b0;
        cnt = len;
        for (int i = 0; i < nsend; i++) begin
            lst = (i == last_idx);
            rr  = (i == bad_idx) ? 2'b11 : 2'b00;
            e   = (rr != 2'b00) || (lst && cnt != 8'd0) || (cnt == 8'd0 && !lst);
            rvalid = 1'b1; rdata = base + 32'(i); rlast = lst; rresp = rr;
            rid = 4'($urandom_range(0, 15));
            exp_q.push_back({e, lst, base + 32'(i)});
            hs = 1'b0; guard = 0;
            while (!hs && guard < 50) begin
                @(negedge clk);
                hs = rready;
                wait_cycle();
                guard++;
            end
            if (!hs) check("r_timeout", 64'd1, 64'd0);
            cnt = (cnt == 8'd0) ? 8'd0 : cnt - 8'd1;
        end
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    endtask

    // Write slave: awready rises aw_at cycles and wready w_at cycles after the
    // valids appear, then both stay high so any repeated valid would re-handshake.
    task automatic slave_write(input int aw_at, input int w_at, input logic [1:0] resp);
        int guard = 0;
        int top;
        logic hs;
        while (!awvalid && guard < 50) begin
            wait_cycle();
            guard++;
        end
        check("aw_w_together", {62'd0, awvalid, wvalid}, 64'd3);
        top = (aw_at > w_at) ? aw_at : w_at;
        for (int c = 0; c <= top + 2; c++) begin
            awready = (c >= aw_at);
            wready  = (c >= w_at);
            wait_cycle();
        end
        awready = 1'b0; wready = 1'b0;
        bvalid = 1'b1; bresp = resp; bid = 4'($urandom_range(0, 15));
        exp_q.push_back({(resp != 2'b00), 1'b1, 32'd0});
        hs = 1'b0; guard = 0;
        while (!hs && guard < 50) begin
            @(negedge clk);
            hs = bready;
            wait_cycle();
            guard++;
        end
        if (!hs) check("b_timeout", 64'd1, 64'd0);
        bvalid = 1'b0; bresp = 2'b00;
    endtask

    task automatic end_txn(input string tag);
        check({tag, "_idle"}, fsm_state, ST_IDLE);
        check({tag, "_drained"}, exp_q.size(), 64'd0);
    endtask

    task automatic do_write(input int aw_at, input int w_at, input logic [1:0] resp, input string tag);
        int r0;
        aw_cnt = 0; w_cnt = 0; r0 = resp_cnt;
        send_req(1'b1, 32'hA000_03F8, 8'($urandom_range(0, 255)), 32'h1234_5678, 4'b0011);
        check({tag, "_wreq_latency"}, {62'd0, awvalid, wvalid}, 64'd3);
        slave_write(aw_at, w_at, resp);
        check({tag, "_aw_count"}, aw_cnt, 64'd1);
        check({tag, "_w_count"}, w_cnt, 64'd1);
        check({tag, "_resp_count"}, resp_cnt - r0, 64'd1);
        end_txn(tag);
    endtask

    initial begin
        int r0;
        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
        req_wdata = '0; req_wstrb = '0;
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
        bvalid = 1'b0; bresp = '0; bid = '0;
        rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rid = '0;
        repeat (3) wait_cycle();
        check("rst_valids", {58'd0, arvalid, awvalid, wvalid, rready, bready, resp_valid}, 64'd0);
        rst_n = 1'b1;
        wait_cycle();
        check("rst_req_ready", req_ready, 64'd1);
        check("rst_resp_valid", resp_valid, 64'd0);
        check("rst_state", fsm_state, ST_IDLE);

        // Single-beat read.
        r0 = resp_cnt;
        send_req(1'b0, 32'h8000_0000, 8'd0, 32'd0, 4'd0);
        check("rd1_ar_latency", arvalid, 64'd1);
        slave_read(8'd0, 1, 0, -1, 32'hDEAD_BEEF);
        check("rd1_resp_count", resp_cnt - r0, 64'd1);
        end_txn("rd1");

        // Four-beat read with resp_ready toggling.
        rr_toggle = 1'b1;
        r0 = resp_cnt;
        send_req(1'b0, 32'h8000_0100, 8'd3, 32'd0, 4'd0);
        slave_read(8'd3, 4, 3, -1, 32'h5000_0000);
        rr_toggle = 1'b0;
        wait_cycle();
        check("rd4_resp_count", resp_cnt - r0, 64'd4);
        end_txn("rd4");

        // Writes: awready late, wready late, both together; then SLVERR.
        do_write(3, 0, 2'b00, "wr_aw_late");
        do_write(0, 3, 2'b00, "wr_w_late");
        do_write(0, 0, 2'b00, "wr_same");
        do_write(1, 2, 2'b10, "wr_slverr");

        // Read with a DECERR on the middle beat.
        send_req(1'b0, 32'h8000_0200, 8'd2, 32'd0, 4'd0);
        slave_read(8'd2, 3, 2, 1, 32'h6000_0000);
        end_txn("rd_decerr");

        // Slave ends a two-beat read early.
        send_req(1'b0, 32'h8000_0300, 8'd1, 32'd0, 4'd0);
        slave_read(8'd1, 1, 0, -1, 32'h7000_0000);
        end_txn("rd_early_last");

        // Slave overruns: beat 2 of a two-beat read lacks rlast; a third carries it.
        send_req(1'b0, 32'h8000_0400, 8'd1, 32'd0, 4'd0);
        slave_read(8'd1, 3, 2, -1, 32'h7100_0000);
        end_txn("rd_overrun");

        // Reset mid-burst after two beats of an eight-beat read.
        send_req(1'b0, 32'h8000_0500, 8'd7, 32'd0, 4'd0);
        slave_read(8'd7, 2, -1, -1, 32'h9000_0000);
        rvalid = 1'b1; rdata = 32'h9000_0002;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valids", {58'd0, arvalid, awvalid, wvalid, rready, bready, resp_valid}, 64'd0);
        check("midrst_state", fsm_state, ST_IDLE);
        rvalid = 1'b0;
        exp_q.delete();
        wait_cycle();
        wait_cycle();
        rst_n = 1'b1;
        wait_cycle();
        check("postrst_req_ready", req_ready, 64'd1);
        check("postrst_resp_valid", resp_valid, 64'd0);
        r0 = resp_cnt;
        send_req(1'b0, 32'h8000_0600, 8'd1, 32'd0, 4'd0);
        slave_read(8'd1, 2, 1, -1, 32'hA5A5_0000);
        check("postrst_resp_count", resp_cnt - r0, 64'd2);
        end_txn("postrst");

        repeat (3) wait_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi4_master_bridge.md
AXI4_MASTER_BRIDGE -- requirements
Module: axi4_master_bridge

Interface
REQ-001 SHALL have parameter AXI_ID, default 4'h0: constant value driven on awid and arid.
REQ-002 SHALL have clock  in  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have req_valid/req_ready  in/out  1/1  request handshake from the core-side client.
REQ-005 SHALL have req_write  in  1  1=write, 0=read.
REQ-006 SHALL have req_addr  in  32  byte address.
REQ-007 SHALL have req_len  in  8  read beats minus 1; ignored for writes.
REQ-008 SHALL have req_wdata/req_wstrb  in  32/4  write data and byte strobes.
REQ-009 SHALL have resp_valid/resp_ready  out/in  1/1  response handshake to the client.
REQ-010 SHALL have resp_data, resp_last, resp_err  out  32/1/1  read beat data, final beat, error.
REQ-011 SHALL have full AXI4 master ports (aw*, w*, b*, ar*, r*) with 32-bit data, 4-bit id, 8-bit len, 3-bit size, 2-bit burst.

Function
REQ-012 SHALL use FSM states IDLE, RADDR, RDATA, WREQ, WRESP; req_ready=1 only in IDLE.
REQ-013 SHALL latch addr, len, wdata and wstrb on the req handshake; IDLE->RADDR for a read, IDLE->WREQ for a write.
REQ-014 SHALL hold arvalid=1 in RADDR with latched araddr/arlen, arsize=3'b010, arburst=2'b01; on arready go to RDATA.
REQ-015 SHALL in RDATA drive rready=resp_ready, resp_valid=rvalid, resp_data=rdata, resp_last=rlast, resp_err=(rresp!=0)|beat-count mismatch.
REQ-016 SHALL keep an 8-bit beat counter loaded from len; it decrements on each r handshake; beat-count mismatch = rlast with counter!=0, or counter==0 without rlast.
REQ-017 SHALL return RDATA->IDLE on the r handshake with rlast=1; a counter-0 beat without rlast is still forwarded with resp_err=1, and the FSM continues until rlast.
REQ-018 SHALL in WREQ assert awvalid and wvalid together (awlen=0, awsize=3'b010, awburst=2'b01, wlast=1), each deasserting independently on its own handshake.
REQ-019 SHALL track aw_done/w_done flags; WREQ->WRESP once both handshakes are done, in either order or in the same cycle.
REQ-020 SHALL in WRESP drive bready=resp_ready, resp_valid=bvalid, resp_err=(bresp!=0), resp_last=1, resp_data=0; on the b handshake go to IDLE.
REQ-021 SHALL deassert arvalid, awvalid, wvalid, rready and bready in every state not named above for them.
REQ-022 SHALL hold all AXI payload signals stable while the corresponding valid is high and unacknowledged.
REQ-023 SHALL give request-to-arvalid and request-to-awvalid/wvalid latency of one cycle; back-to-back requests are accepted the cycle after return to IDLE.
REQ-024 SHALL ignore rid and bid.

Reset
REQ-025 SHALL on reset assertion immediately force state=IDLE, all valids/readies driven by the block=0, aw_done=w_done=0, counter=0; req_ready=1 and resp_valid=0 after release.
REQ-026 SHALL abandon any transaction in flight on reset, with no completion response.

Structure
REQ-027 SHALL place the FSM state enum, AXI burst/size/resp constants and memory-map base constants in shared package axi4_pkg.
REQ-028 SHALL be a single module with no sub-modules.

Verification
REQ-029 Read len=0 at 0x80000000, slave returns 0xDEADBEEF rlast=1 rresp=0 -> one response, data 0xDEADBEEF, last=1, err=0; back to IDLE.
REQ-030 Read len=3 at 0x80000100, resp_ready toggled every other cycle -> 4 in-order beats, last only on beat 4, no lost or duplicated beats.
REQ-031 Write 0x12345678 wstrb=4'b0011 to 0xa00003f8: awready 3 cycles after wready, then the reverse order, then both ready in the same cycle -> exactly one aw and one w handshake each, one response err=0.
REQ-032 bresp=2'b10 on a write, and rresp=2'b11 on a read beat -> resp_err=1 on that response.
REQ-033 Read len=1 where the slave asserts rlast on beat 1 -> beat 1 forwarded with err=1, last=1; FSM returns to IDLE.
REQ-034 Reset asserted mid-burst after beat 2 of len=7 -> all valids 0 within the same cycle; after release req_ready=1 and a new read completes normally.
